// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider/fp32 dispatch controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic MODE_DIV  = 1'b0;
  localparam logic MODE_FP32 = 1'b1;

  localparam int SIGN_BIT = 64;
  localparam int HI_MSB   = 63;
  localparam int HI_LSB   = 32;
  localparam int LO_MSB   = 31;
  localparam int LO_LSB   = 0;

  localparam logic [64:0] TIMEOUT_FILL = {65{1'b1}};

endpackage

// File: rtl/div_ctrl_watchdog.sv
// Clear/enable cycle counter that flags the last allowed cycle of a wait window.
module div_ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Counter parks at the terminal value so it cannot wrap if the owner lingers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/div_dispatch_ctrl.sv
// Pops one job, routes it to the divider or fp32 engine, and holds the packed result for the output FIFO.
module div_dispatch_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 65,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [DATA_WIDTH-1:0] job_data,
  input  logic                  job_mode,
  output logic                  div_valid_in,
  output logic                  div_sign,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [WIDTH-1:0]      div_r,
  input  logic                  div_sign_o,
  output logic                  fp_valid_in,
  output logic [63:0]           fp_din,
  input  logic                  fp_ready,
  input  logic                  fp_valid_out,
  input  logic [31:0]           fp_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  job_cnt
);

  state_t                state;
  logic [DATA_WIDTH-1:0] job_q;
  logic                  mode_q;
  logic                  wd_expired;

  div_ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != S_WAIT),
    .enable (state == S_WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      job_q        <= '0;
      mode_q       <= MODE_DIV;
      div_valid_in <= 1'b0;
      fp_valid_in  <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      timeout_err  <= 1'b0;
      job_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            job_q        <= job_data;
            mode_q       <= job_mode;
            div_valid_in <= (job_mode == MODE_DIV);
            fp_valid_in  <= (job_mode == MODE_FP32);
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mode_q == MODE_DIV) begin
            div_valid_in <= 1'b0;
            state        <= S_WAIT;
          end else if (fp_ready) begin
            fp_valid_in <= 1'b0;
            state       <= S_WAIT;
          end
        end
        // A real completion takes priority over the watchdog firing in the same cycle.
        S_WAIT: begin
          if (mode_q == MODE_DIV && div_done) begin
            res_data  <= {div_sign_o, div_q, div_r};
            res_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (mode_q == MODE_FP32 && fp_valid_out) begin
            res_data  <= {job_q[SIGN_BIT], fp_result, 32'b0};
            res_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (wd_expired) begin
            res_data    <= TIMEOUT_FILL;
            timeout_err <= 1'b1;
            res_valid   <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_cnt   <= job_cnt + CNT_WIDTH'(1);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign job_ready    = (state == S_IDLE) && !reset;
  assign busy         = (state != S_IDLE);
  assign div_sign     = job_q[SIGN_BIT];
  assign div_dividend = job_q[HI_MSB:HI_LSB];
  assign div_divisor  = job_q[LO_MSB:LO_LSB];
  assign fp_din       = job_q[HI_MSB:LO_LSB];

endmodule

// File: doc/div_dispatch_ctrl.md
# div_dispatch_ctrl

Single-job dispatch controller between the 65-bit input FIFO and the two arithmetic engines: the radix-2 integer divider and the fp32 converter. It pops one job and routes it by its mode bit. It sequences the selected engine's handshake, packs the result into the 65-bit output word and holds it until the output FIFO accepts it. It also provides a watchdog, a completed-job counter and a busy flag.

## Interface
- DATA_WIDTH, 65, job/result word width (bit 64 sign, 63:32 high operand, 31:0 low operand)
- WIDTH, 32, divider operand/result width
- TIMEOUT_CYCLES, 256, max cycles spent in WAIT before abort
- CNT_WIDTH, 16, completed-job counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- job_valid  in  1  input FIFO has a job
- job_ready  out  1  job accepted this cycle when both high
- job_data  in  DATA_WIDTH  job word
- job_mode  in  1  0 = radix-2 divide, 1 = fp32
- div_valid_in  out  1  one-cycle start pulse to divider
- div_sign  out  1  job sign bit to divider
- div_dividend, div_divisor  out  WIDTH  job_data[63:32], job_data[31:0]
- div_done  in  1  divider result valid pulse
- div_q, div_r  in  WIDTH  quotient, remainder
- div_sign_o  in  1  divider result sign
- fp_valid_in  out  1  fp32 request, held until fp_ready
- fp_din  out  64  job_data[63:0]
- fp_ready  in  1  fp32 engine accepts request
- fp_valid_out  in  1  fp32 result valid pulse
- fp_result  in  32  fp32 result
- res_valid  out  1  result word valid
- res_ready  in  1  output FIFO accepts result
- res_data  out  DATA_WIDTH  result word
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag
- job_cnt  out  CNT_WIDTH  completed (handed-off) jobs, wraps

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - job_ready = 1.
  - On job_valid, latch job_data and job_mode, then go to ISSUE.
- ISSUE, div mode:
  - Assert div_valid_in for exactly one cycle, then go to WAIT.
- ISSUE, fp mode:
  - Assert fp_valid_in and stay in ISSUE until fp_ready is sampled high.
  - Go to WAIT the cycle after the handshake.
- WAIT: the watchdog counter increments each cycle. Exit on the selected engine's done:
  - div: res_data = {div_sign_o, div_q, div_r}.
  - fp: res_data = {latched job bit 64, fp_result, 32'b0}.
  - Go to HOLD.
- WAIT timeout: when the counter reaches TIMEOUT_CYCLES-1 with no done:
  - res_data = all ones; set timeout_err (cleared only by reset).
  - Go to HOLD.
- HOLD:
  - res_valid = 1; res_data stays stable.
  - On res_ready, increment job_cnt (wraps from 2^CNT_WIDTH-1 to 0) and go to IDLE.
- Done pulses from either engine are ignored outside WAIT. The done pulse from the non-selected engine is also ignored in WAIT.
- Operand outputs (div_*, fp_din) are driven from the latched job and stay stable from ISSUE through HOLD.

## Timing
- Reset values: job_ready 0 during reset, then 1 in IDLE. div_valid_in, fp_valid_in, res_valid, busy and timeout_err are 0. res_data and job_cnt are 0. Watchdog is 0.
- Reset asserted in any state returns the FSM to IDLE next cycle. Any in-flight job is dropped and no result is emitted.
- Div path, no backpressure: accept at cycle 0, div_valid_in at cycle 1, WAIT from cycle 2. With done at cycle N, res_valid goes high at N+1, and job_ready is back at the cycle after the res handshake.
- Fp path: same, with ISSUE extended by the fp_ready wait cycles.
- Only one job in flight. job_ready is low in ISSUE, WAIT and HOLD.
- Done and timeout in the same cycle: done wins, the real result is captured and timeout_err is not set.
- Watchdog clears on entering WAIT. Cycles spent in ISSUE are not counted.

## Structure
- Package div_ctrl_pkg holds:
  - state enum
  - MODE_DIV = 0, MODE_FP32 = 1
  - field offsets: SIGN_BIT = 64, HI = 63:32, LO = 31:0
  - the timeout fill constant
- Sub-module div_ctrl_watchdog: clear/enable counter with terminal-count output, parameterized by TIMEOUT_CYCLES.

## Test plan
- Div job {0, 100, 7}, mode 0; engine returns done 34 cycles after start with q = 14, r = 2, sign 0 -> one div_valid_in pulse; res_data = {0, 14, 2}; job_cnt = 1.
- Fp job, mode 1, fp_ready low for 3 cycles; result 0x3F800000 -> fp_valid_in held 4 cycles; res_data[63:32] = 0x3F800000, res_data[31:0] = 0.
- res_ready low for 10 cycles in HOLD -> res_valid and res_data stable; job_ready low; a second job is not popped until the handshake.
- No done for 256 cycles -> res_data = all ones; timeout_err = 1 and stays 1 after subsequent normal jobs.
- Reset pulsed mid-WAIT, then a late div_done -> IDLE with all outputs at reset values; the done is ignored; no res_valid.
- Spurious div_done in IDLE and fp_valid_out during a div job -> no state change, no captured data.
- Complete 65,536 jobs with CNT_WIDTH = 16 -> job_cnt wraps to 0.
